// File: rtl/ibex_instr_mem_responder.sv
// Instruction-fetch bus responder backed by a synchronous single-cycle SRAM.
// Grants word fetches, reads the SRAM, and returns in-order responses a fixed
// RespLatency cycles after grant. Fetches outside [MemBase, MemBase+MemSizeBytes)
// complete with an error and never touch the SRAM.
//
// Ports:
//   clk_i, rst_ni              clock, asynchronous active-low reset
//   instr_req_i, instr_addr_i  fetch request and byte address ([1:0] ignored)
//   instr_gnt_o                request accepted this cycle (combinational)
//   instr_rvalid_o/rdata_o/err_o  response channel
//   gnt_stall_i                blocks new grants while high
//   mem_req_o, mem_addr_o      SRAM read enable and word-aligned byte address
//   mem_rdata_i                SRAM read data, valid the cycle after mem_req_o
//   busy_o                     at least one granted fetch is unanswered
module ibex_instr_mem_responder #(
   parameter int unsigned MaxOutstanding = 2,
   parameter int unsigned RespLatency    = 1,
   parameter logic [31:0] MemBase        = 32'h0000_0000,
   parameter logic [31:0] MemSizeBytes   = 32'h0001_0000,
   parameter bit          ResetAll       = 1'b0
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        instr_req_i,
   input  logic [31:0] instr_addr_i,
   output logic        instr_gnt_o,
   output logic        instr_rvalid_o,
   output logic [31:0] instr_rdata_o,
   output logic        instr_err_o,
   input  logic        gnt_stall_i,
   output logic        mem_req_o,
   output logic [31:0] mem_addr_o,
   input  logic [31:0] mem_rdata_i,
   output logic        busy_o
);

   localparam int unsigned CntW = $clog2(MaxOutstanding + 1);

   logic [CntW-1:0] outstanding_q, outstanding_d;
   logic [32:0]     addr_off;
   logic            in_range;
   logic            s0_valid, s0_err;
   logic            rsp_valid, rsp_err;
   logic [31:0]     rsp_data;

   // 33-bit difference: bit 32 set means the address lies below MemBase.
   assign addr_off = {1'b0, instr_addr_i} - {1'b0, MemBase};
   assign in_range = ~addr_off[32] && (addr_off[31:0] < MemSizeBytes);

   // The limit uses the registered count, so a full window blocks the grant
   // even in a cycle where a response retires.
   assign instr_gnt_o = instr_req_i & ~gnt_stall_i &
                        (outstanding_q < CntW'(MaxOutstanding));
   assign mem_req_o   = instr_gnt_o & in_range;
   assign mem_addr_o  = {instr_addr_i[31:2], 2'b00};

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         s0_valid <= 1'b0;
      end else begin
         s0_valid <= instr_gnt_o;
      end
   end

   if (ResetAll) begin : g_s0_rst
      always_ff @(posedge clk_i or negedge rst_ni) begin
         if (!rst_ni) begin
            s0_err <= 1'b0;
         end else if (instr_gnt_o) begin
            s0_err <= ~in_range;
         end
      end
   end else begin : g_s0_nr
      always_ff @(posedge clk_i) begin
         if (instr_gnt_o) begin
            s0_err <= ~in_range;
         end
      end
   end

   if (RespLatency == 1) begin : g_lat1
      assign rsp_valid = s0_valid;
      assign rsp_err   = s0_valid & s0_err;
      assign rsp_data  = (s0_valid & ~s0_err) ? mem_rdata_i : 32'h0;
   end else begin : g_latn
      localparam int unsigned NumStages = RespLatency - 1;

      logic [NumStages-1:0] p_valid;
      logic [NumStages:0]   valid_chain;
      logic [32:0]          p_word    [NumStages];
      logic [32:0]          p_word_in [NumStages];

      // valid_chain[k] is the valid bit arriving at stage k this cycle.
      assign valid_chain = {p_valid, s0_valid};

      always_comb begin
         p_word_in[0] = {s0_err, s0_err ? 32'h0 : mem_rdata_i};
         for (int k = 1; k < NumStages; k++) begin
            p_word_in[k] = p_word[k-1];
         end
      end

      always_ff @(posedge clk_i or negedge rst_ni) begin
         if (!rst_ni) begin
            p_valid <= '0;
         end else begin
            p_valid <= valid_chain[NumStages-1:0];
         end
      end

      if (ResetAll) begin : g_data_rst
         always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
               for (int k = 0; k < NumStages; k++) p_word[k] <= '0;
            end else begin
               for (int k = 0; k < NumStages; k++) begin
                  if (valid_chain[k]) p_word[k] <= p_word_in[k];
               end
            end
         end
      end else begin : g_data_nr
         always_ff @(posedge clk_i) begin
            for (int k = 0; k < NumStages; k++) begin
               if (valid_chain[k]) p_word[k] <= p_word_in[k];
            end
         end
      end

      assign rsp_valid = p_valid[NumStages-1];
      assign rsp_err   = p_valid[NumStages-1] & p_word[NumStages-1][32];
      assign rsp_data  = p_valid[NumStages-1] ? p_word[NumStages-1][31:0] : 32'h0;
   end

   assign instr_rvalid_o = rsp_valid;
   assign instr_err_o    = rsp_err;
   assign instr_rdata_o  = rsp_data;

   always_comb begin
      outstanding_d = outstanding_q;
      unique case ({instr_gnt_o, rsp_valid})
         2'b10:   outstanding_d = outstanding_q + CntW'(1);
         2'b01:   outstanding_d = outstanding_q - CntW'(1);
         default: outstanding_d = outstanding_q;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         outstanding_q <= '0;
      end else begin
         outstanding_q <= outstanding_d;
      end
   end

   assign busy_o = (outstanding_q != '0);

   always_ff @(posedge clk_i) begin
      if (rst_ni) begin
         assert (RespLatency >= 1 && RespLatency <= 4 &&
                 MaxOutstanding >= 1 && MaxOutstanding <= 8 &&
                 MemSizeBytes[1:0] == 2'b00);
         assert (outstanding_q <= CntW'(MaxOutstanding));
         assert (!instr_rvalid_o || (outstanding_q != '0));
      end
   end

endmodule

// File: tb/tb_ibex_instr_mem_responder.sv
module tb_ibex_instr_mem_responder;

   localparam int MAXO  = 2;
   localparam int LAT_A = 1;
   localparam int LAT_B = 3;

   typedef struct {
      int          due;
      logic        err;
      logic [31:0] data;
   } exp_t;

   logic        clk, rst_n;
   logic        a_req, a_stall, a_gnt, a_rvalid, a_err, a_mreq, a_busy;
   logic [31:0] a_addr, a_rdata, a_maddr, a_mrdata;
   logic        b_req, b_stall, b_gnt, b_rvalid, b_err, b_mreq, b_busy;
   logic [31:0] b_addr, b_rdata, b_maddr, b_mrdata;

   logic        s_a_gnt, s_a_rvalid, s_a_err, s_a_mreq, s_a_busy;
   logic [31:0] s_a_rdata, s_a_maddr;
   logic        s_b_gnt, s_b_rvalid, s_b_err, s_b_mreq, s_b_busy;
   logic [31:0] s_b_rdata, s_b_maddr;

   exp_t qa[$];
   exp_t qb[$];
   int   n_chk  = 0;
   int   n_fail = 0;
   int   cyc    = 0;

   ibex_instr_mem_responder #(
      .MaxOutstanding(MAXO), .RespLatency(LAT_A),
      .MemBase(32'h0), .MemSizeBytes(32'h0001_0000), .ResetAll(1'b0)
   ) u_a (
      .clk_i(clk), .rst_ni(rst_n),
      .instr_req_i(a_req), .instr_addr_i(a_addr), .instr_gnt_o(a_gnt),
      .instr_rvalid_o(a_rvalid), .instr_rdata_o(a_rdata), .instr_err_o(a_err),
      .gnt_stall_i(a_stall), .mem_req_o(a_mreq), .mem_addr_o(a_maddr),
      .mem_rdata_i(a_mrdata), .busy_o(a_busy)
   );

   ibex_instr_mem_responder #(
      .MaxOutstanding(MAXO), .RespLatency(LAT_B),
      .MemBase(32'h0), .MemSizeBytes(32'h0001_0000), .ResetAll(1'b1)
   ) u_b (
      .clk_i(clk), .rst_ni(rst_n),
      .instr_req_i(b_req), .instr_addr_i(b_addr), .instr_gnt_o(b_gnt),
      .instr_rvalid_o(b_rvalid), .instr_rdata_o(b_rdata), .instr_err_o(b_err),
      .gnt_stall_i(b_stall), .mem_req_o(b_mreq), .mem_addr_o(b_maddr),
      .mem_rdata_i(b_mrdata), .busy_o(b_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] word_at(input logic [31:0] a);
      if (a == 32'h0000_0100) return 32'h0000_0513;
      return (a ^ 32'h5A5A_0000) + 32'h13;
   endfunction

   function automatic logic in_win(input logic [31:0] a);
      return a < 32'h0001_0000;
   endfunction

   // SRAM models: one-cycle read latency.
   always @(posedge clk) if (a_mreq) a_mrdata <= word_at(a_maddr);
   always @(posedge clk) if (b_mreq) b_mrdata <= word_at(b_maddr);

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic sb_step(input bit id, input string nm, input int lat,
                          input logic req, input logic stall, input logic [31:0] addr,
                          input logic gnt, input logic mreq, input logic [31:0] maddr,
                          input logic rvalid, input logic err, input logic [31:0] rdata,
                          input logic busy);
      int   sz;
      exp_t f;
      exp_t e;
      logic win;
      sz  = id ? qb.size() : qa.size();
      win = in_win(addr);
      chk($sformatf("%s busy c%0d", nm, cyc), 32'(busy), 32'(sz != 0));
      chk($sformatf("%s gnt c%0d", nm, cyc), 32'(gnt), 32'(req & ~stall & (sz < MAXO)));
      chk($sformatf("%s mem_req c%0d", nm, cyc), 32'(mreq), 32'(gnt & win));
      if (gnt) chk($sformatf("%s mem_addr c%0d", nm, cyc), maddr, {addr[31:2], 2'b00});
      if (sz != 0) begin
         if (id) f = qb[0];
         else    f = qa[0];
      end
      if (rvalid) begin
         if (sz == 0) begin
            chk($sformatf("%s unexpected rvalid c%0d", nm, cyc), 32'(rvalid), 32'(0));
         end else begin
            if (id) void'(qb.pop_front());
            else    void'(qa.pop_front());
            chk($sformatf("%s rsp cycle", nm), 32'(cyc), 32'(f.due));
            chk($sformatf("%s rsp err c%0d", nm, cyc), 32'(err), 32'(f.err));
            chk($sformatf("%s rsp data c%0d", nm, cyc), rdata, f.data);
         end
      end else if (sz != 0) begin
         chk($sformatf("%s rvalid missing c%0d", nm, cyc), 32'(rvalid), 32'(f.due == cyc));
      end
      if (gnt) begin
         e.due  = cyc + lat;
         e.err  = ~win;
         e.data = win ? word_at({addr[31:2], 2'b00}) : 32'h0;
         if (id) qb.push_back(e);
         else    qa.push_back(e);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      s_a_gnt = a_gnt; s_a_rvalid = a_rvalid; s_a_err = a_err; s_a_mreq = a_mreq;
      s_a_busy = a_busy; s_a_rdata = a_rdata; s_a_maddr = a_maddr;
      s_b_gnt = b_gnt; s_b_rvalid = b_rvalid; s_b_err = b_err; s_b_mreq = b_mreq;
      s_b_busy = b_busy; s_b_rdata = b_rdata; s_b_maddr = b_maddr;
      sb_step(1'b0, "A", LAT_A, a_req, a_stall, a_addr, a_gnt, a_mreq, a_maddr,
              a_rvalid, a_err, a_rdata, a_busy);
      sb_step(1'b1, "B", LAT_B, b_req, b_stall, b_addr, b_gnt, b_mreq, b_maddr,
              b_rvalid, b_err, b_rdata, b_busy);
      @(posedge clk);
      #1;
      cyc++;
   endtask

   initial begin
      logic [7:0] m_g, m_v, m_b;
      logic [9:0] exp_g, exp_v;
      int         idx;

      rst_n = 1'b1;
      a_req = 1'b0; a_stall = 1'b0; a_addr = 32'h0;
      b_req = 1'b0; b_stall = 1'b0; b_addr = 32'h0;
      #1 rst_n = 1'b0;
      #1;
      chk("reset a_gnt", 32'(a_gnt), 32'(0));
      chk("reset a_rvalid", 32'(a_rvalid), 32'(0));
      chk("reset a_err", 32'(a_err), 32'(0));
      chk("reset a_mem_req", 32'(a_mreq), 32'(0));
      chk("reset a_busy", 32'(a_busy), 32'(0));
      chk("reset b_rvalid", 32'(b_rvalid), 32'(0));
      chk("reset b_rdata", b_rdata, 32'h0);
      chk("reset b_busy", 32'(b_busy), 32'(0));
      @(posedge clk);
      @(posedge clk);
      #1 rst_n = 1'b1;

      // Single fetch at 0x100, granted in cycle 5.
      m_g = 8'b0010_0000; m_v = 8'b0100_0000; m_b = 8'b0100_0000;
      for (int i = 0; i < 8; i++) begin
         a_req  = (i == 5);
         a_addr = 32'h100;
         tick();
         chk($sformatf("single gnt i%0d", i), 32'(s_a_gnt), 32'(m_g[i]));
         chk($sformatf("single rvalid i%0d", i), 32'(s_a_rvalid), 32'(m_v[i]));
         chk($sformatf("single busy i%0d", i), 32'(s_a_busy), 32'(m_b[i]));
         if (i == 5) chk("single mem_addr", s_a_maddr, 32'h100);
         if (i == 6) begin
            chk("single rdata", s_a_rdata, 32'h0000_0513);
            chk("single err", 32'(s_a_err), 32'(0));
         end
      end

      // Window edge: first byte past the window, then last word inside it.
      for (int i = 0; i < 4; i++) begin
         a_req  = (i < 2);
         a_addr = (i == 0) ? 32'h0001_0000 : 32'h0000_FFFC;
         tick();
         if (i == 0) begin
            chk("oow gnt", 32'(s_a_gnt), 32'(1));
            chk("oow mem_req", 32'(s_a_mreq), 32'(0));
         end
         if (i == 1) begin
            chk("oow rvalid", 32'(s_a_rvalid), 32'(1));
            chk("oow err", 32'(s_a_err), 32'(1));
            chk("oow rdata", s_a_rdata, 32'h0);
            chk("edge mem_req", 32'(s_a_mreq), 32'(1));
         end
         if (i == 2) begin
            chk("edge rvalid", 32'(s_a_rvalid), 32'(1));
            chk("edge err", 32'(s_a_err), 32'(0));
            chk("edge rdata", s_a_rdata, word_at(32'h0000_FFFC));
         end
      end

      // Grant stall for cycles 2..4 with the request held.
      m_g = 8'b0010_0010; m_v = 8'b0100_0100;
      idx = 0;
      for (int i = 0; i < 8; i++) begin
         a_req   = (i >= 1 && i <= 5);
         a_stall = (i >= 2 && i <= 4);
         a_addr  = 32'h200 + 32'(idx * 4);
         tick();
         chk($sformatf("stall gnt i%0d", i), 32'(s_a_gnt), 32'(m_g[i]));
         chk($sformatf("stall rvalid i%0d", i), 32'(s_a_rvalid), 32'(m_v[i]));
         if (s_a_gnt) idx++;
      end
      a_stall = 1'b0;

      // Misaligned address returns the containing word.
      for (int i = 0; i < 3; i++) begin
         a_req  = (i == 0);
         a_addr = 32'h102;
         tick();
         if (i == 0) begin
            chk("misalign gnt", 32'(s_a_gnt), 32'(1));
            chk("misalign mem_addr", s_a_maddr, 32'h100);
         end
         if (i == 1) begin
            chk("misalign rvalid", 32'(s_a_rvalid), 32'(1));
            chk("misalign rdata", s_a_rdata, 32'h0000_0513);
         end
      end

      // Streaming on the latency-3 instance.
      exp_g = 10'b00_0011_0011;
      exp_v = 10'b01_1001_1000;
      idx = 0;
      for (int i = 0; i < 10; i++) begin
         b_req  = (idx < 4);
         b_addr = 32'(idx * 4);
         tick();
         chk($sformatf("stream gnt i%0d", i), 32'(s_b_gnt), 32'(exp_g[i]));
         chk($sformatf("stream rvalid i%0d", i), 32'(s_b_rvalid), 32'(exp_v[i]));
         if (s_b_gnt) idx++;
      end
      b_req = 1'b0;
      for (int i = 0; i < 3; i++) tick();

      // Reset with two fetches in flight.
      for (int i = 0; i < 2; i++) begin
         b_req  = 1'b1;
         b_addr = 32'h40 + 32'(i * 4);
         tick();
         chk($sformatf("rst pre gnt i%0d", i), 32'(s_b_gnt), 32'(1));
      end
      b_req = 1'b0;
      rst_n = 1'b0;
      #1;
      chk("rst busy immediate", 32'(b_busy), 32'(0));
      chk("rst rvalid immediate", 32'(b_rvalid), 32'(0));
      qa.delete();
      qb.delete();
      tick();
      rst_n = 1'b1;
      for (int i = 0; i < 6; i++) tick();
      for (int i = 0; i < 2; i++) begin
         b_req  = 1'b1;
         b_addr = 32'h80 + 32'(i * 4);
         tick();
         chk($sformatf("rst post gnt i%0d", i), 32'(s_b_gnt), 32'(1));
      end
      b_req = 1'b0;
      for (int i = 0; i < 6; i++) tick();

      chk("drain A", 32'(qa.size()), 32'(0));
      chk("drain B", 32'(qb.size()), 32'(0));

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
